// File: rtl/od_line_receiver.sv
// Open-drain single-wire bus receiver: sync, deglitch, pulse-width decode,
// LSB-first byte assembly and valid/ready delivery.
module od_line_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3,
    parameter int SHORT_MAX   = 15,
    parameter int LONG_MAX    = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       bus_reset,
    output logic       overrun,
    input  logic       clr_err,
    output logic       busy
);

    localparam int LW = $clog2(LONG_MAX + 2);
    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [LW-1:0] LSAT  = LW'(LONG_MAX + 1);
    localparam logic [LW-1:0] LMAX  = LW'(LONG_MAX);
    localparam logic [LW-1:0] SMAX  = LW'(SHORT_MAX);
    localparam logic [FW-1:0] FLAST = FW'(FILTER - 1);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t           state;
    state_t           state_n;
    logic             line;
    logic [SYNC_STAGES-1:0] sync;
    logic             s;
    logic             filt;
    logic [FW-1:0]    cnt;
    logic [LW-1:0]    low_cnt;
    logic [LW-1:0]    low_n;
    logic             decode;
    logic [2:0]       bcnt;
    logic [7:0]       shreg;
    logic [7:0]       new_byte;
    logic             bit_val;
    logic             is_long;
    logic             shift_en;
    logic             long_rst;
    logic             done;
    logic             load;
    logic             drop;

    // Anything other than a driven 0 (1, z, x) is the pulled-up level.
    assign line = (bus_in === 1'b0) ? 1'b0 : 1'b1;
    assign s    = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else if (SYNC_STAGES > 1) begin
            sync <= {sync[SYNC_STAGES-2:0], line};
        end else begin
            sync <= line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (s == filt) begin
            cnt <= '0;
        end else if (cnt == FLAST) begin
            filt <= s;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        low_n   = low_cnt;
        decode  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!filt) begin
                    state_n = MEAS;
                    low_n   = LW'(1);
                end
            end
            MEAS: begin
                if (!filt) begin
                    if (low_cnt != LSAT) low_n = low_cnt + 1'b1;
                end else begin
                    state_n = IDLE;
                    decode  = 1'b1;
                end
            end
        endcase
    end

    assign is_long  = low_cnt > LMAX;
    assign bit_val  = low_cnt <= SMAX;
    assign shift_en = decode && !is_long;
    assign long_rst = decode && is_long;
    assign new_byte = {bit_val, shreg[7:1]};
    assign done     = shift_en && (bcnt == 3'd7);
    assign load     = done && (!data_valid || data_ready);
    assign drop     = done && data_valid && !data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            low_cnt <= '0;
        end else begin
            state   <= state_n;
            low_cnt <= low_n;
        end
    end

    // Bit counter wraps 7->0 on completion; an over-long low drops the partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt      <= '0;
            shreg     <= '0;
            bus_reset <= 1'b0;
        end else begin
            bus_reset <= long_rst;
            if (long_rst) begin
                bcnt <= '0;
            end else if (shift_en) begin
                bcnt  <= bcnt + 1'b1;
                shreg <= new_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                data_out   <= new_byte;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
        end
    end

    assign busy = (state == MEAS) || (bcnt != 3'd0);

endmodule

// File: tb/tb_od_line_receiver.sv
// Bench for od_line_receiver: vector table, directed corner sequences and
// random pulse trains against a pulse-width-level reference model.
module tb_od_line_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER      = 3;
    localparam int SHORT_MAX   = 15;
    localparam int LONG_MAX    = 60;
    localparam int GAP         = 20;

    logic       clk;
    logic       rst_n;
    logic       drv_low;
    logic       drv_x;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       bus_reset;
    logic       overrun;
    logic       clr_err;
    logic       busy;
    tri1        bus;

    assign bus = drv_low ? 1'b0 : (drv_x ? 1'bx : 1'bz);

    od_line_receiver #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER(FILTER),
        .SHORT_MAX(SHORT_MAX),
        .LONG_MAX(LONG_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_in(bus),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .bus_reset(bus_reset),
        .overrun(overrun),
        .clr_err(clr_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_pulses = 0;

    always @(negedge clk) if (bus_reset === 1'b1) n_pulses++;

    // Reference model: tracks decoded bits per pulse, not per cycle.
    int         m_bits = 0;
    logic [7:0] m_byte = '0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_ovr = 1'b0;
    int         m_resets = 0;

    function automatic void model_pulse(int w);
        if (w < FILTER) return;
        if (w > LONG_MAX) begin
            m_resets++;
            m_bits = 0;
            return;
        end
        m_byte[m_bits] = (w <= SHORT_MAX);
        m_bits++;
        if (m_bits == 8) begin
            m_bits = 0;
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = m_byte;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, "_valid"}, 32'(data_valid), 32'(m_valid));
        chk({tag, "_data"}, 32'(data_out), 32'(m_data));
        chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        chk({tag, "_busy"}, 32'(busy), 32'(m_bits != 0));
        chk({tag, "_rstcnt"}, 32'(n_pulses), 32'(m_resets));
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // kind 0 drives a low, kind 1 drives x; model follows what the line shows.
    task automatic phase(int w, int kind, int gap);
        logic seen_low;
        drv_low = (kind == 0);
        drv_x   = (kind == 1);
        #1;
        seen_low = (bus === 1'b0);
        cyc(w);
        drv_low = 1'b0;
        drv_x   = 1'b0;
        cyc(gap);
        if (seen_low) model_pulse(w);
    endtask

    task automatic send_byte(logic [7:0] b);
        for (int i = 0; i < 8; i++) phase(b[i] ? 6 : 40, 0, GAP);
    endtask

    // Last bit's decode edge coincides with the given ready/clear levels.
    task automatic send_byte_edge(logic [7:0] b, logic rdy, logic clr);
        int w;
        for (int i = 0; i < 7; i++) phase(b[i] ? 6 : 40, 0, GAP);
        w = b[7] ? 6 : 40;
        drv_low = 1'b1;
        cyc(w);
        drv_low = 1'b0;
        cyc(SYNC_STAGES + FILTER);
        data_ready = rdy;
        clr_err    = clr;
        cyc(1);
        data_ready = 1'b0;
        clr_err    = 1'b0;
        cyc(GAP - SYNC_STAGES - FILTER - 1);
        if (clr) m_ovr = 1'b0;
        if (rdy) m_valid = 1'b0;
        model_pulse(w);
    endtask

    task automatic ack();
        data_ready = 1'b1;
        cyc(1);
        data_ready = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic clear();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        m_ovr = 1'b0;
    endtask

    typedef struct {
        int         w;
        int         kind;
        logic [7:0] exp_byte;
        int         exp_rst;
    } vec_t;

    vec_t vecs[9];
    int   n0;

    initial begin
        vecs[0] = '{2, 0, 8'hFF, 0};
        vecs[1] = '{3, 0, 8'hFF, 0};
        vecs[2] = '{6, 0, 8'hFF, 0};
        vecs[3] = '{15, 0, 8'hFF, 0};
        vecs[4] = '{16, 0, 8'hFE, 0};
        vecs[5] = '{40, 0, 8'hFE, 0};
        vecs[6] = '{60, 0, 8'hFE, 0};
        vecs[7] = '{61, 0, 8'hFF, 1};
        vecs[8] = '{10, 1, 8'hFF, 0};

        rst_n = 1'b0;
        drv_low = 1'b0;
        drv_x = 1'b0;
        data_ready = 1'b0;
        clr_err = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        chk("rst_bus_reset", 32'(bus_reset), 32'd0);
        chk_model("reset");

        for (int i = 0; i < 10; i++) begin
            cyc(20);
            chk_model("idle");
        end

        send_byte(8'hA5);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk_model("a5");
        cyc(30);
        chk("a5_hold", 32'(data_valid), 32'd1);
        data_ready = 1'b1;
        #1;
        chk("a5_pre_edge", 32'(data_valid), 32'd1);
        cyc(1);
        data_ready = 1'b0;
        m_valid = 1'b0;
        chk("a5_drop", 32'(data_valid), 32'd0);

        for (int i = 0; i < 9; i++) begin
            n0 = n_pulses;
            phase(vecs[i].w, vecs[i].kind, GAP);
            for (int k = 0; k < 7; k++) phase(6, 0, GAP);
            chk_model($sformatf("vec%0d", i));
            if (!m_valid) phase(6, 0, GAP);
            chk($sformatf("vec%0d_byte", i), 32'(data_out), 32'(vecs[i].exp_byte));
            chk($sformatf("vec%0d_rst", i), 32'(n_pulses - n0), 32'(vecs[i].exp_rst));
            chk_model($sformatf("vec%0d_end", i));
            ack();
        end

        n0 = n_pulses;
        phase(6, 0, GAP);
        phase(40, 0, GAP);
        phase(6, 0, GAP);
        phase(100, 0, GAP);
        chk("long_busy", 32'(busy), 32'd0);
        send_byte(8'h3C);
        chk("long_rst", 32'(n_pulses - n0), 32'd1);
        chk("long_data", 32'(data_out), 32'h3C);
        chk_model("long");
        ack();

        send_byte(8'h11);
        send_byte(8'h22);
        chk("ovr_data", 32'(data_out), 32'h11);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk_model("ovr");
        clear();
        chk("ovr_clr", 32'(overrun), 32'd0);
        send_byte_edge(8'h22, 1'b1, 1'b0);
        chk("same_edge_data", 32'(data_out), 32'h22);
        chk("same_edge_valid", 32'(data_valid), 32'd1);
        chk("same_edge_ovr", 32'(overrun), 32'd0);
        send_byte_edge(8'h33, 1'b0, 1'b1);
        chk("set_wins", 32'(overrun), 32'd1);
        chk_model("set_wins");

        for (int i = 0; i < 4; i++) phase(6, 0, GAP);
        drv_low = 1'b1;
        cyc(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(data_valid), 32'd0);
        chk("arst_data", 32'(data_out), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_brst", 32'(bus_reset), 32'd0);
        drv_low = 1'b0;
        cyc(10);
        rst_n = 1'b1;
        m_bits = 0;
        m_valid = 1'b0;
        m_data = '0;
        m_ovr = 1'b0;
        cyc(5);
        send_byte(8'h5A);
        chk("after_rst_data", 32'(data_out), 32'h5A);
        chk_model("after_rst");
        ack();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0)
                phase($urandom_range(3, 12), 1, $urandom_range(8, 25));
            else
                phase($urandom_range(1, 80), 0, $urandom_range(8, 25));
            chk_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) ack();
            if ($urandom_range(0, 7) == 0) clear();
        end
        chk_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/od_line_receiver.md
Name: od_line_receiver

Overview:
Receive side of the open-drain, wired-AND single-wire bus. Drivers pull the line to 0 or release it to high-Z. This block samples the resolved line and treats any non-0 value (1, z, x) as high, giving pull-up semantics. It then synchronizes and deglitches the line, and decodes low-pulse widths into bits: a short low is a 1, a long low is a 0. Bits are assembled LSB-first into bytes and delivered over a valid/ready handshake to the local controller.

Parameters:
SYNC_STAGES, 2, synchronizer flops on bus_in (min 2)
FILTER, 3, consecutive identical synchronized samples required to change the filtered level (min 1)
SHORT_MAX, 15, max low width in cycles decoded as bit 1
LONG_MAX, 60, max low width in cycles decoded as bit 0; wider lows are bus resets (LONG_MAX > SHORT_MAX)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
bus_in  input  1  wired-AND bus line; may carry 0, 1, z or x
data_out  output  8  last accepted byte, LSB received first
data_valid  output  1  data_out holds an unconsumed byte
data_ready  input  1  consumer accepts byte when data_valid && data_ready
bus_reset  output  1  one-cycle pulse: over-long low detected
overrun  output  1  sticky: a completed byte was dropped
clr_err  input  1  synchronous clear of overrun
busy  output  1  bit counter non-zero or low pulse in progress

Behaviour:
- Line resolution: the input to the first sync flop is 0 only when bus_in === 1'b0. Otherwise it is 1 (z/x read as pulled-up).
- Reset (async, rst_n=0): sync chain and filtered level are set to 1. data_out=0x00, data_valid=0, bus_reset=0, overrun=0, busy=0. FSM=IDLE. Bit count, shift register and low counter are cleared.
- Filter: cnt increments each cycle the sync output s differs from filt, and resets to 0 when s==filt.
  - When s!=filt and cnt==FILTER-1: filt<=s, cnt<=0.
  - Lows shorter than FILTER cycles never reach filt.
  - For clean pulses of width W>=FILTER, filt stays low exactly W cycles.
- FSM states: IDLE, MEAS.
  - IDLE: when filt==0, go to MEAS with low_cnt=1.
  - MEAS, filt==0: low_cnt increments, saturating at LONG_MAX+1.
  - MEAS, filt==1: decode on this edge, return to IDLE.
    - low_cnt<=SHORT_MAX: shift in 1.
    - SHORT_MAX<low_cnt<=LONG_MAX: shift in 0.
    - low_cnt>LONG_MAX: pulse bus_reset for 1 cycle, discard the partial byte (bit count=0), shift nothing.
- Widths: low_cnt is $clog2(LONG_MAX+2) bits. Bit count is 3 bits and wraps 7->0 on byte completion.
- Byte completion (8th bit shifted in):
  - If data_valid==0, or data_valid && data_ready on the same cycle: data_out<=new byte, data_valid<=1.
  - Else: byte dropped, data_out unchanged, overrun<=1.
- Handshake: data_valid holds until data_ready is sampled high. It then drops on the next edge, unless a new byte loads on that same edge, in which case it stays 1.
- clr_err clears overrun. If clr_err and a new overrun occur on the same cycle, overrun stays set (set wins).
- Latency: the raw bus release reaches filt after SYNC_STAGES+FILTER cycles. The decode/data_valid update occurs on the following edge.
- busy = (FSM==MEAS) || (bit count!=0). Nothing times out while the line idles high; a partial byte persists until completed or bus_reset.

Test Plan:
1. After reset, bus_in=z for 200 cycles -> busy=0, data_valid=0, bus_reset never pulses, data_out=0x00.
2. Send 0xA5 LSB-first: lows of 6 cycles (bit 1) or 40 cycles (bit 0), 20 cycles z between pulses, data_ready=0 -> data_valid=1 with data_out=0xA5. It stays 1 until data_ready=1 for 1 cycle, then 0 next edge.
3. Boundaries: low widths 15, 16, 60, 61 -> bits 1, 0, 0, then bus_reset pulse; 2-cycle low glitch and 10 cycles of x -> no bit recorded.
4. Send 3 bits, then a 100-cycle low, then 0x3C -> one bus_reset pulse on release; data_out=0x3C (partial bits discarded).
5. Send 0x11 then 0x22 with data_ready=0 -> data_out=0x11, overrun=1. Assert clr_err -> overrun=0. Repeat with data_ready=1 on the completion edge of 0x22 -> data_out=0x22, data_valid stays 1, overrun=0.
6. Assert rst_n=0 mid-byte (after 4 bits, line held low) -> all outputs reset immediately, no clock needed. Release reset, send 0x5A -> data_out=0x5A.
